// File: rtl/izh_pkg.sv
// rtl/izh_pkg.sv - Q9.7 Izhikevich constants, widths, FSM state type and saturation helper
package izh_pkg;

    localparam int DW   = 16;
    localparam int CW   = 8;
    localparam int ACCW = 32;
    localparam int FRAC = 7;

    localparam logic signed [DW-1:0] A      = 16'sd3;      // 0.02
    localparam logic signed [DW-1:0] B      = 16'sd26;     // 0.2
    localparam logic signed [DW-1:0] C      = -16'sd8320;  // -65.0
    localparam logic signed [DW-1:0] D      = 16'sd1024;   // 8.0
    localparam logic signed [DW-1:0] THRESH = 16'sh0F00;   // 30.0

    localparam logic signed [ACCW-1:0] A32    = ACCW'(A);
    localparam logic signed [ACCW-1:0] B32    = ACCW'(B);
    localparam logic signed [ACCW-1:0] D32    = ACCW'(D);
    localparam logic signed [ACCW-1:0] K_QUAD = 32'sd5;     // 0.04 in Q9.7
    localparam logic signed [ACCW-1:0] K_LIN  = 32'sd5;     // plain integer gain
    localparam logic signed [ACCW-1:0] V_OFS  = 32'sd17920; // 140.0

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        UPD  = 2'd2,
        DONE = 2'd3
    } izh_state_e;

    function automatic logic signed [DW-1:0] sat16(input logic signed [ACCW-1:0] x);
        if (x > 32'sd32767) begin
            return 16'sh7FFF;
        end else if (x < -32'sd32768) begin
            return 16'sh8000;
        end else begin
            return x[DW-1:0];
        end
    endfunction

endpackage

// File: rtl/izh_update.sv
// rtl/izh_update.sv - combinational one-step Euler update of a single Izhikevich neuron
module izh_update
    import izh_pkg::*;
(
    input  logic signed [DW-1:0] v_i,
    input  logic signed [DW-1:0] u_i,
    input  logic        [CW-1:0] cur_i,
    output logic signed [DW-1:0] v_next_o,
    output logic signed [DW-1:0] u_next_o,
    output logic                 spike_o
);

    logic signed [ACCW-1:0] v_ext;
    logic signed [ACCW-1:0] u_ext;
    logic signed [ACCW-1:0] cur_ext;
    logic signed [ACCW-1:0] v_sq;
    logic signed [ACCW-1:0] quad;
    logic signed [ACCW-1:0] lin;
    logic signed [ACCW-1:0] v_sum;
    logic signed [ACCW-1:0] bv;
    logic signed [ACCW-1:0] du;
    logic signed [ACCW-1:0] u_sum;
    logic signed [ACCW-1:0] u_rst;

    always_comb begin
        v_ext   = ACCW'(v_i);
        u_ext   = ACCW'(u_i);
        cur_ext = ACCW'(cur_i) <<< FRAC;
        // v' = v + 0.04 v^2 + 5 v + 140 - u + I ; u' = u + a (b v - u)
        v_sq    = (v_ext * v_ext) >>> FRAC;
        quad    = (K_QUAD * v_sq) >>> FRAC;
        lin     = K_LIN * v_ext;
        v_sum   = v_ext + quad + lin + V_OFS - u_ext + cur_ext;
        bv      = (B32 * v_ext) >>> FRAC;
        du      = (A32 * (bv - u_ext)) >>> FRAC;
        u_sum   = u_ext + du;
        u_rst   = u_ext + D32;
        spike_o = (v_i >= THRESH);
        if (spike_o) begin
            v_next_o = C;
            u_next_o = sat16(u_rst);
        end else begin
            v_next_o = sat16(v_sum);
            u_next_o = sat16(u_sum);
        end
    end

endmodule

// File: rtl/izh_tdm_sched.sv
// rtl/izh_tdm_sched.sv - time-multiplexed sweep scheduler sharing one izh_update datapath
module izh_tdm_sched
    import izh_pkg::*;
#(
    parameter int NEURONS = 4,
    parameter int IDW     = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tick,
    input  logic                cur_we,
    input  logic [IDW-1:0]      cur_addr,
    input  logic [CW-1:0]       cur_data,
    input  logic                st_we,
    input  logic [IDW-1:0]      st_addr,
    input  logic [DW-1:0]       st_v,
    output logic                busy,
    output logic                done,
    output logic                spk_valid,
    output logic [IDW-1:0]      spk_id,
    input  logic                spk_ready,
    output logic                overrun
);

    localparam logic [IDW-1:0] LAST_IDX = IDW'(NEURONS - 1);

    izh_state_e state_q, state_d;
    logic [IDW-1:0] idx_q, idx_d;

    logic signed [DW-1:0] v_q   [NEURONS];
    logic signed [DW-1:0] v_d   [NEURONS];
    logic signed [DW-1:0] u_q   [NEURONS];
    logic signed [DW-1:0] u_d   [NEURONS];
    logic        [CW-1:0] cur_q [NEURONS];
    logic        [CW-1:0] cur_d [NEURONS];

    logic signed [DW-1:0] op_v_q, op_v_d;
    logic signed [DW-1:0] op_u_q, op_u_d;
    logic        [CW-1:0] op_cur_q, op_cur_d;

    logic           spk_valid_q, spk_valid_d;
    logic [IDW-1:0] spk_id_q, spk_id_d;
    logic           overrun_q, overrun_d;

    logic signed [DW-1:0] v_next;
    logic signed [DW-1:0] u_next;
    logic                 upd_spike;
    logic                 stall;

    izh_update u_update (
        .v_i      (op_v_q),
        .u_i      (op_u_q),
        .cur_i    (op_cur_q),
        .v_next_o (v_next),
        .u_next_o (u_next),
        .spike_o  (upd_spike)
    );

    // A new spike can only be accepted once the output slot is free or draining.
    assign stall = upd_spike && spk_valid_q && !spk_ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        v_d         = v_q;
        u_d         = u_q;
        cur_d       = cur_q;
        op_v_d      = op_v_q;
        op_u_d      = op_u_q;
        op_cur_d    = op_cur_q;
        spk_valid_d = spk_valid_q && !spk_ready;
        spk_id_d    = spk_id_q;
        overrun_d   = overrun_q || (tick && (state_q != IDLE));

        if (cur_we) begin
            cur_d[cur_addr] = cur_data;
        end

        case (state_q)
            IDLE: begin
                if (st_we) begin
                    v_d[st_addr] = st_v;
                end
                if (tick) begin
                    state_d = RD;
                    idx_d   = '0;
                end
            end
            RD: begin
                op_v_d   = v_q[idx_q];
                op_u_d   = u_q[idx_q];
                op_cur_d = cur_q[idx_q];
                state_d  = UPD;
            end
            UPD: begin
                if (!stall) begin
                    v_d[idx_q] = v_next;
                    u_d[idx_q] = u_next;
                    if (upd_spike) begin
                        spk_valid_d = 1'b1;
                        spk_id_d    = idx_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = RD;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            op_v_q      <= '0;
            op_u_q      <= '0;
            op_cur_q    <= '0;
            spk_valid_q <= 1'b0;
            spk_id_q    <= '0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < NEURONS; i++) begin
                v_q[i]   <= '0;
                u_q[i]   <= '0;
                cur_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            op_v_q      <= op_v_d;
            op_u_q      <= op_u_d;
            op_cur_q    <= op_cur_d;
            spk_valid_q <= spk_valid_d;
            spk_id_q    <= spk_id_d;
            overrun_q   <= overrun_d;
            v_q         <= v_d;
            u_q         <= u_d;
            cur_q       <= cur_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign spk_valid = spk_valid_q;
    assign spk_id    = spk_id_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_izh_tdm_sched.sv
// tb/tb_izh_tdm_sched.sv - directed self-checking bench for izh_tdm_sched
module tb_izh_tdm_sched;
    import izh_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        tick;
    logic        cur_we;
    logic [1:0]  cur_addr;
    logic [7:0]  cur_data;
    logic        st_we;
    logic [1:0]  st_addr;
    logic [15:0] st_v;
    logic        busy;
    logic        done;
    logic        spk_valid;
    logic [1:0]  spk_id;
    logic        spk_ready;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    izh_tdm_sched #(.NEURONS(4), .IDW(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick      (tick),
        .cur_we    (cur_we),
        .cur_addr  (cur_addr),
        .cur_data  (cur_data),
        .st_we     (st_we),
        .st_addr   (st_addr),
        .st_v      (st_v),
        .busy      (busy),
        .done      (done),
        .spk_valid (spk_valid),
        .spk_id    (spk_id),
        .spk_ready (spk_ready),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        tick      = 1'b0;
        cur_we    = 1'b0;
        cur_addr  = '0;
        cur_data  = '0;
        st_we     = 1'b0;
        st_addr   = '0;
        st_v      = '0;
        spk_ready = 1'b1;
        repeat (2) cyc();
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            cyc();
            n++;
        end
    endtask

    task automatic preload(input logic [1:0] a, input logic [15:0] val);
        st_we   = 1'b1;
        st_addr = a;
        st_v    = val;
        cyc();
        st_we   = 1'b0;
    endtask

    function automatic int sat(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic void model(input int v, input int u, input int c,
                                  output int vn, output int un);
        int sq;
        if (v >= 3840) begin
            vn = -8320;
            un = sat(u + 1024);
        end else begin
            sq = (v * v) >>> 7;
            vn = sat(v + ((5 * sq) >>> 7) + 5 * v + 17920 - u + c * 128);
            un = sat(u + ((3 * (((26 * v) >>> 7) - u)) >>> 7));
        end
    endfunction

    task automatic test_reset();
        do_reset();
        total++;
        if ({busy, done, spk_valid, spk_id, overrun} !== 6'b0) begin
            $display("FAIL reset_outputs: got %b want 000000", {busy, done, spk_valid, spk_id, overrun});
            bad++;
        end
        total++;
        if (dut.v_q[3] !== 16'h0000 || dut.u_q[3] !== 16'h0000) begin
            $display("FAIL reset_state: got v=%h u=%h want 0000", dut.v_q[3], dut.u_q[3]);
            bad++;
        end
    endtask

    task automatic test_basic_sweep();
        int busy_err = 0;
        int done_err = 0;
        int spk_seen = 0;
        do_reset();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (busy !== 1'b1) busy_err++;
            if (done !== (c == 9)) done_err++;
            if (spk_valid !== 1'b0) spk_seen++;
            cyc();
        end
        total++;
        if (busy_err != 0) begin
            $display("FAIL sweep_busy: got %0d low cycles want 0", busy_err);
            bad++;
        end
        total++;
        if (done_err != 0) begin
            $display("FAIL sweep_done_timing: got %0d wrong cycles want 0", done_err);
            bad++;
        end
        total++;
        if (spk_seen != 0 || busy !== 1'b0) begin
            $display("FAIL sweep_end: got spikes=%0d busy=%b want 0 0", spk_seen, busy);
            bad++;
        end
        total++;
        if (dut.v_q[0] !== 16'h4600 || dut.v_q[3] !== 16'h4600 || dut.u_q[2] !== 16'h0000) begin
            $display("FAIL sweep_values: got v0=%h v3=%h u2=%h want 4600 4600 0000",
                     dut.v_q[0], dut.v_q[3], dut.u_q[2]);
            bad++;
        end
    endtask

    task automatic test_model_step();
        int n;
        do_reset();
        preload(2'd1, 16'hDF80);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        wait_done(20, n);
        total++;
        if (dut.v_q[1] !== 16'hD585 || dut.u_q[1] !== 16'hFFD8 || done !== 1'b1) begin
            $display("FAIL euler_step: got v=%h u=%h done=%b want D585 FFD8 1",
                     dut.v_q[1], dut.u_q[1], done);
            bad++;
        end
    endtask

    task automatic test_spike();
        int n;
        do_reset();
        spk_ready = 1'b0;
        preload(2'd2, 16'h1000);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        wait_done(20, n);
        total++;
        if (spk_valid !== 1'b1 || spk_id !== 2'd2 || done !== 1'b1) begin
            $display("FAIL spike_event: got valid=%b id=%0d done=%b want 1 2 1", spk_valid, spk_id, done);
            bad++;
        end
        total++;
        if (dut.v_q[2] !== 16'hDF80 || dut.u_q[2] !== 16'h0400) begin
            $display("FAIL spike_reset: got v=%h u=%h want DF80 0400", dut.v_q[2], dut.u_q[2]);
            bad++;
        end
        spk_ready = 1'b1;
        cyc();
        total++;
        if (spk_valid !== 1'b0) begin
            $display("FAIL spike_accept: got valid=%b want 0", spk_valid);
            bad++;
        end
    endtask

    task automatic test_stall();
        do_reset();
        spk_ready = 1'b0;
        preload(2'd1, 16'h1000);
        preload(2'd3, 16'h1000);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        repeat (12) cyc();
        total++;
        if (dut.state_q !== UPD || dut.idx_q !== 2'd3 || busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL stall_hold: got state=%0d idx=%0d busy=%b done=%b want 2 3 1 0",
                     dut.state_q, dut.idx_q, busy, done);
            bad++;
        end
        total++;
        if (spk_valid !== 1'b1 || spk_id !== 2'd1 || dut.v_q[3] !== 16'h1000) begin
            $display("FAIL stall_slot: got valid=%b id=%0d v3=%h want 1 1 1000", spk_valid, spk_id, dut.v_q[3]);
            bad++;
        end
        spk_ready = 1'b1;
        cyc();
        total++;
        if (spk_valid !== 1'b1 || spk_id !== 2'd3 || done !== 1'b1) begin
            $display("FAIL stall_release: got valid=%b id=%0d done=%b want 1 3 1", spk_valid, spk_id, done);
            bad++;
        end
        cyc();
        total++;
        if (spk_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || dut.v_q[3] !== 16'hDF80) begin
            $display("FAIL stall_drain: got valid=%b done=%b busy=%b v3=%h want 0 0 0 DF80",
                     spk_valid, done, busy, dut.v_q[3]);
            bad++;
        end
    endtask

    task automatic test_overrun();
        int pulses = 0;
        int spikes = 0;
        do_reset();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        cyc();
        tick    = 1'b1;
        st_we   = 1'b1;
        st_addr = 2'd3;
        st_v    = 16'h1000;
        cyc();
        tick  = 1'b0;
        st_we = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (done === 1'b1) pulses++;
            if (spk_valid === 1'b1) spikes++;
            cyc();
        end
        total++;
        if (pulses != 1) begin
            $display("FAIL overrun_done_count: got %0d want 1", pulses);
            bad++;
        end
        total++;
        if (overrun !== 1'b1 || spikes != 0 || dut.v_q[3] !== 16'h4600) begin
            $display("FAIL overrun_flag: got overrun=%b spikes=%0d v3=%h want 1 0 4600",
                     overrun, spikes, dut.v_q[3]);
            bad++;
        end
    endtask

    task automatic test_cur_write();
        int n;
        int vn;
        int un;
        do_reset();
        cur_we   = 1'b1;
        cur_addr = 2'd0;
        cur_data = 8'd10;
        cyc();
        cur_we = 1'b0;
        tick   = 1'b1;
        cyc();
        tick     = 1'b0;
        cur_we   = 1'b1;
        cur_data = 8'd50;
        cyc();
        cur_we = 1'b0;
        wait_done(20, n);
        model(0, 0, 10, vn, un);
        total++;
        if (dut.v_q[0] !== 16'h4B00 || dut.v_q[0] !== 16'(vn) || dut.u_q[0] !== 16'(un)) begin
            $display("FAIL cur_old_used: got v=%h u=%h want 4B00 %h", dut.v_q[0], dut.u_q[0], 16'(un));
            bad++;
        end
        cyc();
        preload(2'd0, 16'h0000);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        wait_done(20, n);
        model(0, 0, 50, vn, un);
        total++;
        if (dut.v_q[0] !== 16'h5F00 || dut.v_q[0] !== 16'(vn) || dut.cur_q[0] !== 8'd50) begin
            $display("FAIL cur_new_used: got v=%h cur=%0d want 5F00 50", dut.v_q[0], dut.cur_q[0]);
            bad++;
        end
    endtask

    task automatic test_back_to_back();
        int hits = 0;
        do_reset();
        tick    = 1'b1;
        st_we   = 1'b1;
        st_addr = 2'd3;
        st_v    = 16'h1000;
        cyc();
        tick  = 1'b0;
        st_we = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (spk_valid === 1'b1 && spk_id === 2'd3) hits++;
            cyc();
        end
        total++;
        if (hits != 1 || dut.v_q[3] !== 16'hDF80) begin
            $display("FAIL tick_with_preload: got hits=%0d v3=%h want 1 DF80", hits, dut.v_q[3]);
            bad++;
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        do_reset();
        spk_ready = 1'b0;
        preload(2'd1, 16'h1000);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        cyc();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        total++;
        if (spk_valid !== 1'b1 || spk_id !== 2'd1 || overrun !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL midreset_pre: got valid=%b id=%0d overrun=%b busy=%b want 1 1 1 1",
                     spk_valid, spk_id, overrun, busy);
            bad++;
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({busy, done, spk_valid, spk_id, overrun} !== 6'b0 || dut.v_q[1] !== 16'h0000) begin
            $display("FAIL midreset_async: got %b v1=%h want 000000 0000",
                     {busy, done, spk_valid, spk_id, overrun}, dut.v_q[1]);
            bad++;
        end
        reset_n = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (done === 1'b1) pulses++;
            cyc();
        end
        total++;
        if (pulses != 0 || busy !== 1'b0) begin
            $display("FAIL midreset_no_done: got pulses=%0d busy=%b want 0 0", pulses, busy);
            bad++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_model_step();
        test_spike();
        test_stall();
        test_overrun();
        test_cur_write();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
